// File: rtl/robot_maze_top.sv
// Maze-walking robot on a 10x20 grid using a left-hand wall-following rule.
// memo_inst holds the map and the robot pose; the top derives sensors and picks one action per clock.

module robot_maze_memo #(
  parameter logic [1599:0] MAP_IMAGE = '0,
  parameter int            START_ROW = 9,
  parameter int            START_COL = 0,
  parameter int            START_DIR = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] robo_row_d,
  input  logic [5:0] robo_col_d,
  input  logic [1:0] robo_orientacao_d,
  input  logic       wr_en,
  input  logic [7:0] wr_idx,
  input  logic [7:0] f_idx,
  input  logic [7:0] l_idx,
  input  logic [7:0] c_idx,
  output logic [7:0] f_raw,
  output logic [7:0] l_raw,
  output logic [7:0] c_raw,
  output logic [4:0] robo_row,
  output logic [5:0] robo_col,
  output logic [1:0] robo_orientacao
);

  logic [7:0] map_q [0:199];
  logic [7:0] map   [0:199];
  logic [4:0] robo_row_q;
  logic [5:0] robo_col_q;
  logic [1:0] robo_orientacao_q;

  // Reset restores both the pose and the full map image, so cleared rubble reappears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 200; i++) begin
        map_q[i] <= MAP_IMAGE[i*8 +: 8];
      end
      robo_row_q        <= 5'(START_ROW);
      robo_col_q        <= 6'(START_COL);
      robo_orientacao_q <= 2'(START_DIR);
    end else begin
      if (wr_en) begin
        map_q[wr_idx] <= 8'd0;
      end
      robo_row_q        <= robo_row_d;
      robo_col_q        <= robo_col_d;
      robo_orientacao_q <= robo_orientacao_d;
    end
  end

  assign map             = map_q;
  assign robo_row        = robo_row_q;
  assign robo_col        = robo_col_q;
  assign robo_orientacao = robo_orientacao_q;
  assign f_raw           = map_q[f_idx];
  assign l_raw           = map_q[l_idx];
  assign c_raw           = map_q[c_idx];

endmodule

module robot_maze_top #(
  parameter logic [1599:0] MAP_IMAGE = '0,
  parameter int            START_ROW = 9,
  parameter int            START_COL = 0,
  parameter int            START_DIR = 0
) (
  input  logic clk,
  input  logic reset
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_CLEAR = 3'd1,
    ACT_FWD   = 3'd2,
    ACT_TL    = 3'd3,
    ACT_TR    = 3'd4
  } act_t;

  localparam logic [1:0] CELL_WALL   = 2'd1;
  localparam logic [1:0] CELL_RUBBLE = 2'd2;
  localparam logic [1:0] CELL_EXIT   = 2'd3;

  function automatic logic signed [6:0] d_row(input logic [1:0] d);
    case (d)
      2'd0:    d_row = -7'sd1;
      2'd2:    d_row = 7'sd1;
      default: d_row = 7'sd0;
    endcase
  endfunction

  function automatic logic signed [6:0] d_col(input logic [1:0] d);
    case (d)
      2'd1:    d_col = 7'sd1;
      2'd3:    d_col = -7'sd1;
      default: d_col = 7'sd0;
    endcase
  endfunction

  function automatic logic in_grid(input logic signed [6:0] r, input logic signed [6:0] c);
    return (r >= 7'sd0) && (r < 7'sd10) && (c >= 7'sd0) && (c < 7'sd20);
  endfunction

  function automatic logic [7:0] cell_idx(input logic signed [6:0] r, input logic signed [6:0] c);
    return ({1'b0, r} * 8'd20) + {1'b0, c};
  endfunction

  // Unknown codes are treated as wall so a corrupt cell never lets the robot through.
  function automatic logic [1:0] cell_code(input logic [7:0] raw);
    return (raw > 8'd3) ? CELL_WALL : raw[1:0];
  endfunction

  logic [4:0] cur_row;
  logic [5:0] cur_col;
  logic [1:0] cur_dir;
  logic [4:0] robo_row_d;
  logic [5:0] robo_col_d;
  logic [1:0] robo_orientacao_d;
  logic       wr_en;
  logic [7:0] f_idx, l_idx, c_idx;
  logic [7:0] f_raw, l_raw, c_raw;
  logic signed [6:0] row_s, col_s, fr_s, fc_s, lr_s, lc_s;
  logic [1:0] left_dir;
  logic       f_in, l_in;
  logic [1:0] f_code, l_code;
  logic       head, left, under, barrier;
  state_t     state_q, state_d;
  act_t       last_q, last_d;

  robot_maze_memo #(
    .MAP_IMAGE (MAP_IMAGE),
    .START_ROW (START_ROW),
    .START_COL (START_COL),
    .START_DIR (START_DIR)
  ) memo_inst (
    .clk               (clk),
    .reset             (reset),
    .robo_row_d        (robo_row_d),
    .robo_col_d        (robo_col_d),
    .robo_orientacao_d (robo_orientacao_d),
    .wr_en             (wr_en),
    .wr_idx            (f_idx),
    .f_idx             (f_idx),
    .l_idx             (l_idx),
    .c_idx             (c_idx),
    .f_raw             (f_raw),
    .l_raw             (l_raw),
    .c_raw             (c_raw),
    .robo_row          (cur_row),
    .robo_col          (cur_col),
    .robo_orientacao   (cur_dir)
  );

  assign left_dir = cur_dir - 2'd1;
  assign row_s    = $signed({2'b00, cur_row});
  assign col_s    = $signed({1'b0, cur_col});
  assign fr_s     = row_s + d_row(cur_dir);
  assign fc_s     = col_s + d_col(cur_dir);
  assign lr_s     = row_s + d_row(left_dir);
  assign lc_s     = col_s + d_col(left_dir);
  assign f_in     = in_grid(fr_s, fc_s);
  assign l_in     = in_grid(lr_s, lc_s);
  assign f_idx    = f_in ? cell_idx(fr_s, fc_s) : 8'd0;
  assign l_idx    = l_in ? cell_idx(lr_s, lc_s) : 8'd0;
  assign c_idx    = cell_idx(row_s, col_s);
  assign f_code   = f_in ? cell_code(f_raw) : CELL_WALL;
  assign l_code   = l_in ? cell_code(l_raw) : CELL_WALL;

  assign head    = (f_code == CELL_WALL);
  assign left    = (l_code == CELL_WALL);
  assign barrier = (f_code == CELL_RUBBLE);
  assign under   = (cell_code(c_raw) == CELL_EXIT);

  // Action priority: halt on exit, clear rubble, finish a left turn, turn left, go, turn right.
  always_comb begin
    state_d           = state_q;
    last_d            = last_q;
    robo_row_d        = cur_row;
    robo_col_d        = cur_col;
    robo_orientacao_d = cur_dir;
    wr_en             = 1'b0;
    if (state_q == HALT) begin
      last_d = last_q;
    end else if (under) begin
      state_d = HALT;
      last_d  = ACT_NONE;
    end else if (barrier) begin
      wr_en  = 1'b1;
      last_d = ACT_CLEAR;
    end else if ((last_q == ACT_TL) && !head) begin
      robo_row_d = fr_s[4:0];
      robo_col_d = fc_s[5:0];
      last_d     = ACT_FWD;
    end else if (!left) begin
      robo_orientacao_d = left_dir;
      last_d            = ACT_TL;
    end else if (!head) begin
      robo_row_d = fr_s[4:0];
      robo_col_d = fc_s[5:0];
      last_d     = ACT_FWD;
    end else begin
      robo_orientacao_d = cur_dir + 2'd1;
      last_d            = ACT_TR;
    end
  end

  // Controller state and last-action flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      last_q  <= ACT_NONE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_robot_maze_top.sv
// Directed bench: six robot instances on hand-built maps, checked against a per-cycle pose table.

module tb_robot_maze_top;

  function automatic logic [1599:0] mk_map(input int kind);
    logic [1599:0] m;
    m = '0;
    for (int r = 0; r < 10; r++) begin
      if (kind == 1 || kind == 4) m[(r*20 + 1)*8 +: 8] = 8'h01;
    end
    if (kind == 2) m[160*8 +: 8] = 8'h06;
    if (kind == 3) m[160*8 +: 8] = 8'h02;
    if (kind == 4) m[140*8 +: 8] = 8'h03;
    return m;
  endfunction

  localparam logic [1599:0] MAP_FREE = mk_map(0);
  localparam logic [1599:0] MAP_COL1 = mk_map(1);
  localparam logic [1599:0] MAP_ODD  = mk_map(2);
  localparam logic [1599:0] MAP_RUB  = mk_map(3);
  localparam logic [1599:0] MAP_EXIT = mk_map(4);

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  robot_maze_top #(.MAP_IMAGE(MAP_COL1), .START_ROW(9), .START_COL(0), .START_DIR(0))
    u_walk (.clk(clk), .reset(reset));
  robot_maze_top #(.MAP_IMAGE(MAP_ODD), .START_ROW(9), .START_COL(0), .START_DIR(0))
    u_turn (.clk(clk), .reset(reset));
  robot_maze_top #(.MAP_IMAGE(MAP_FREE), .START_ROW(9), .START_COL(5), .START_DIR(0))
    u_left (.clk(clk), .reset(reset));
  robot_maze_top #(.MAP_IMAGE(MAP_RUB), .START_ROW(9), .START_COL(0), .START_DIR(0))
    u_rub (.clk(clk), .reset(reset));
  robot_maze_top #(.MAP_IMAGE(MAP_EXIT), .START_ROW(9), .START_COL(0), .START_DIR(0))
    u_exit (.clk(clk), .reset(reset));
  robot_maze_top #(.MAP_IMAGE(MAP_FREE), .START_ROW(9), .START_COL(0), .START_DIR(3))
    u_wrap (.clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int id;
    int row;
    int col;
    int dir;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input int cyc, input int id, input int row, input int col, input int dir);
    vec_t v;
    v.cyc = cyc; v.id = id; v.row = row; v.col = col; v.dir = dir;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic get_pose(input int id, output int r, output int c, output int d);
    case (id)
      0: begin r = int'(u_walk.memo_inst.robo_row); c = int'(u_walk.memo_inst.robo_col); d = int'(u_walk.memo_inst.robo_orientacao); end
      1: begin r = int'(u_turn.memo_inst.robo_row); c = int'(u_turn.memo_inst.robo_col); d = int'(u_turn.memo_inst.robo_orientacao); end
      2: begin r = int'(u_left.memo_inst.robo_row); c = int'(u_left.memo_inst.robo_col); d = int'(u_left.memo_inst.robo_orientacao); end
      3: begin r = int'(u_rub.memo_inst.robo_row);  c = int'(u_rub.memo_inst.robo_col);  d = int'(u_rub.memo_inst.robo_orientacao);  end
      4: begin r = int'(u_exit.memo_inst.robo_row); c = int'(u_exit.memo_inst.robo_col); d = int'(u_exit.memo_inst.robo_orientacao); end
      default: begin r = int'(u_wrap.memo_inst.robo_row); c = int'(u_wrap.memo_inst.robo_col); d = int'(u_wrap.memo_inst.robo_orientacao); end
    endcase
  endtask

  task automatic apply_cycle(input int cyc);
    int r, c, d;
    foreach (vecs[i]) begin
      if (vecs[i].cyc == cyc) begin
        get_pose(vecs[i].id, r, c, d);
        check($sformatf("c%0d_i%0d_row", cyc, vecs[i].id), r, vecs[i].row);
        check($sformatf("c%0d_i%0d_col", cyc, vecs[i].id), c, vecs[i].col);
        check($sformatf("c%0d_i%0d_dir", cyc, vecs[i].id), d, vecs[i].dir);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;

    // Reset pose (cycle 0) for every instance
    add(0, 0, 9, 0, 0); add(0, 1, 9, 0, 0); add(0, 2, 9, 5, 0);
    add(0, 3, 9, 0, 0); add(0, 4, 9, 0, 0); add(0, 5, 9, 0, 3);
    // Straight walk north along column 0
    for (int k = 1; k <= 5; k++) add(k, 0, 9 - k, 0, 0);
    // Wall ahead (code 6 reads as wall), left off-grid: turn right, then go east, turn left, go north
    add(1, 1, 9, 0, 1); add(2, 1, 9, 1, 1); add(3, 1, 9, 1, 0); add(4, 1, 8, 1, 0);
    // Left free: turn left with 0 -> 3 wrap, then forward west twice
    add(1, 2, 9, 5, 3); add(2, 2, 9, 4, 3); add(3, 2, 9, 3, 3);
    // Rubble ahead: clear without moving, then step
    add(1, 3, 9, 0, 0); add(2, 3, 8, 0, 0);
    // Exit at (7,0): reach it, then stay frozen
    add(1, 4, 8, 0, 0); add(2, 4, 7, 0, 0); add(3, 4, 7, 0, 0);
    add(10, 4, 7, 0, 0); add(22, 4, 7, 0, 0);
    // Boxed-in corner facing west: turn right with 3 -> 0 wrap, then forward
    add(1, 5, 9, 0, 0); add(2, 5, 8, 0, 0);

    reset = 1'b1;
    #12;
    reset = 1'b0;
    #1;
    apply_cycle(0);
    check("init_map_rub160", int'(u_rub.memo_inst.map[160]), 2);
    check("init_map_odd160", int'(u_turn.memo_inst.map[160]), 6);
    check("init_map_exit140", int'(u_exit.memo_inst.map[140]), 3);
    check("init_map_wall21", int'(u_walk.memo_inst.map[21]), 1);
    check("init_barrier_rub", int'(u_rub.barrier), 1);
    check("init_head_walk", int'(u_walk.head), 0);
    check("init_left_walk", int'(u_walk.left), 1);
    check("init_head_odd", int'(u_turn.head), 1);
    check("init_barrier_odd", int'(u_turn.barrier), 0);
    check("init_under_exit", int'(u_exit.under), 0);

    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(posedge clk);
      #1;
      apply_cycle(cyc);
      if (cyc == 1) check("rubble_cleared", int'(u_rub.memo_inst.map[160]), 0);
      if (cyc == 1) check("odd_cell_kept", int'(u_turn.memo_inst.map[160]), 6);
      if (cyc == 2) check("under_at_exit", int'(u_exit.under), 1);
      if (cyc >= 3) check($sformatf("halt_row_c%0d", cyc), int'(u_exit.memo_inst.robo_row), 7);
    end

    // Asynchronous reset between edges aborts the run and restores the map
    #2;
    reset = 1'b1;
    #1;
    check("rst_walk_row", int'(u_walk.memo_inst.robo_row), 9);
    check("rst_exit_row", int'(u_exit.memo_inst.robo_row), 9);
    check("rst_left_col", int'(u_left.memo_inst.robo_col), 5);
    check("rst_left_dir", int'(u_left.memo_inst.robo_orientacao), 0);
    check("rst_map_restored", int'(u_rub.memo_inst.map[160]), 2);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_halt_runs", int'(u_exit.memo_inst.robo_row), 8);
    check("post_rst_rub_row", int'(u_rub.memo_inst.robo_row), 9);
    check("post_rst_rub_map", int'(u_rub.memo_inst.map[160]), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
